// File: rtl/display_pkg.sv
// display_pkg: shared display code constants, digit count and frame bundle type
// for the seven-segment scan path.
package display_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned CODE_W     = 4;
    localparam int unsigned IDX_W      = 3;

    typedef logic [CODE_W-1:0] code_t;

    localparam code_t CODE_ZERO   = 4'h0;
    localparam code_t CODE_HYPHEN = 4'h1;
    localparam code_t CODE_P      = 4'h2;
    localparam code_t CODE_A      = 4'h3;
    localparam code_t CODE_S      = 4'h4;
    localparam code_t CODE_F      = 4'h5;
    localparam code_t CODE_I      = 4'h6;
    localparam code_t CODE_L      = 4'h7;
    localparam code_t CODE_N      = 4'h8;
    localparam code_t CODE_E      = 4'h9;
    localparam code_t CODE_BLANK  = 4'hF;

    // One complete display frame: a code, an enable and a decimal point per digit.
    typedef struct packed {
        logic [NUM_DIGITS-1:0][CODE_W-1:0] codes;
        logic [NUM_DIGITS-1:0]             en;
        logic [NUM_DIGITS-1:0]             points;
    } frame_t;

    localparam frame_t FRAME_RESET = '{
        codes:  {NUM_DIGITS{CODE_BLANK}},
        en:     '0,
        points: '0
    };

    // Active-low one-hot digit select for index idx.
    function automatic logic [NUM_DIGITS-1:0] digit_sel_n(input logic [IDX_W-1:0] idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/display_scan_if.sv
// display_scan_if: frame load bus and scanned display outputs.
//   codes[31:0]  digit i code on [4i+3:4i], digit 0 rightmost
//   digit_en     1 = digit shown
//   points       1 = decimal point lit
//   load         one-cycle strobe capturing codes/digit_en/points
//   code_out     code of the selected digit, to the segment lookup
//   digit        active-low digit enables
//   dp           active-low decimal point
//   frame_tick   pulse in the first output cycle of digit 0's slot
//   updated      pulse when a newly loaded frame becomes active
interface display_scan_if;
    import display_pkg::*;

    logic [NUM_DIGITS*CODE_W-1:0] codes;
    logic [NUM_DIGITS-1:0]        digit_en;
    logic [NUM_DIGITS-1:0]        points;
    logic                         load;
    logic [CODE_W-1:0]            code_out;
    logic [NUM_DIGITS-1:0]        digit;
    logic                         dp;
    logic                         frame_tick;
    logic                         updated;

    modport master (
        output codes, digit_en, points, load,
        input  code_out, digit, dp, frame_tick, updated
    );

    modport slave (
        input  codes, digit_en, points, load,
        output code_out, digit, dp, frame_tick, updated
    );

endinterface

// File: rtl/display_scan_timer.sv
// scan_timer: slot counter and digit index for the display scan, plus the
// frame-boundary indication and the registered frame_tick.
//   clk_i, rst_i    clock, synchronous active-high reset
//   slot_o          cycle within the current digit slot
//   index_o         digit currently being scanned
//   boundary_c_o    last cycle of digit 7's slot (combinational)
//   frame_tick_o    registered: high in the output cycle for slot 0, index 0
module scan_timer
    import display_pkg::*;
#(
    parameter int unsigned PRESCALE = 100000,
    localparam int unsigned SLOT_W  = (PRESCALE > 2) ? $clog2(PRESCALE) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic [SLOT_W-1:0] slot_o,
    output logic [IDX_W-1:0]  index_o,
    output logic              boundary_c_o,
    output logic              frame_tick_o
);

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic              frame_tick_q, frame_tick_d;
    logic              slot_end;

    // Next scan position; the index wraps 7 -> 0 through its natural width.
    always_comb begin
        slot_end     = (slot_q == SLOT_W'(PRESCALE - 1));
        slot_d       = slot_end ? '0 : slot_q + SLOT_W'(1);
        index_d      = slot_end ? index_q + IDX_W'(1) : index_q;
        frame_tick_d = (slot_q == '0) && (index_q == '0);
        boundary_c_o = slot_end && (index_q == IDX_W'(NUM_DIGITS - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q       <= '0;
            index_q      <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            index_q      <= index_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign slot_o       = slot_q;
    assign index_o      = index_q;
    assign frame_tick_o = frame_tick_q;

endmodule

// File: rtl/display_scan.sv
// display_scan: time-multiplexed scanner for an eight-digit common-anode
// seven-segment display. Holds a pending and an active frame; the pending frame
// is promoted only at the end of digit 7's slot so a scan never tears.
//   clk_i   system clock
//   rst_i   synchronous, active-high reset
//   bus     display_scan_if.slave: frame load inputs and scanned outputs
module display_scan
    import display_pkg::*;
#(
    parameter int unsigned PRESCALE = 100000,
    parameter int unsigned BLANK    = 2000
) (
    input  logic           clk_i,
    input  logic           rst_i,
    display_scan_if.slave  bus
);

    localparam int unsigned SLOT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [SLOT_W-1:0] slot;
    logic [IDX_W-1:0]  index;
    logic              boundary_c;
    logic              frame_tick;

    frame_t                pend_q, pend_d;
    frame_t                act_q, act_d;
    logic                  pend_valid_q, pend_valid_d;
    logic                  swap_q, swap_d;
    logic [CODE_W-1:0]     code_out_q, code_out_d;
    logic [NUM_DIGITS-1:0] digit_q, digit_d;
    logic                  dp_q, dp_d;
    logic                  updated_q, updated_d;
    logic                  drive;

    scan_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .slot_o       (slot),
        .index_o      (index),
        .boundary_c_o (boundary_c),
        .frame_tick_o (frame_tick)
    );

    // Buffer update and output mux. The boundary promotion reads the old pending
    // contents, so a load on the boundary cycle waits for the following frame.
    always_comb begin
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        act_d        = act_q;
        swap_d       = 1'b0;

        if (boundary_c && pend_valid_q) begin
            act_d        = pend_q;
            pend_valid_d = 1'b0;
            swap_d       = 1'b1;
        end

        if (bus.load) begin
            pend_d       = '{codes: bus.codes, en: bus.digit_en, points: bus.points};
            pend_valid_d = 1'b1;
        end

        drive      = (slot >= SLOT_W'(BLANK)) && act_q.en[index];
        code_out_d = act_q.codes[index];
        digit_d    = drive ? digit_sel_n(index) : '1;
        dp_d       = !(drive && act_q.points[index]);
        // Promotion happens on the boundary edge; delaying by one register lines
        // updated up with the frame_tick of the first new frame.
        updated_d  = swap_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q       <= FRAME_RESET;
            act_q        <= FRAME_RESET;
            pend_valid_q <= 1'b0;
            swap_q       <= 1'b0;
            code_out_q   <= CODE_BLANK;
            digit_q      <= '1;
            dp_q         <= 1'b1;
            updated_q    <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            act_q        <= act_d;
            pend_valid_q <= pend_valid_d;
            swap_q       <= swap_d;
            code_out_q   <= code_out_d;
            digit_q      <= digit_d;
            dp_q         <= dp_d;
            updated_q    <= updated_d;
        end
    end

    assign bus.code_out   = code_out_q;
    assign bus.digit      = digit_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = frame_tick;
    assign bus.updated    = updated_q;

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: directed scenarios plus randomized loads/resets for
// display_scan, checked every cycle against a time-indexed reference model.
module tb_display_scan;

    localparam int P     = 4;
    localparam int B     = 1;
    localparam int FRAME = 8 * P;

    logic clk;
    logic rst;

    display_scan_if bus();

    display_scan #(
        .PRESCALE (P),
        .BLANK    (B)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_upd    = 0;

    // Reference model: m_t is cycles since reset release; scan position is
    // derived arithmetically from it.
    int          m_t;
    logic [31:0] m_act_codes, m_pend_codes;
    logic [7:0]  m_act_en, m_act_pts, m_pend_en, m_pend_pts;
    bit          m_pv;
    bit          m_swapped;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (model t=%0d)", tag, obs, exp, m_t);
    endtask

    task automatic model_reset();
        m_t          = 0;
        m_act_codes  = 32'hFFFF_FFFF;
        m_act_en     = 8'h00;
        m_act_pts    = 8'h00;
        m_pend_codes = 32'hFFFF_FFFF;
        m_pend_en    = 8'h00;
        m_pend_pts   = 8'h00;
        m_pv         = 1'b0;
        m_swapped    = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.load = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_code_out", 32'(bus.code_out), 32'hF);
        check("rst_digit", 32'(bus.digit), 32'hFF);
        check("rst_dp", 32'(bus.dp), 32'h1);
        check("rst_frame_tick", 32'(bus.frame_tick), 32'h0);
        check("rst_updated", 32'(bus.updated), 32'h0);
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: drive inputs, predict outputs for the state at m_t, advance model.
    task automatic step(input bit ld, input logic [31:0] c, input logic [7:0] e, input logic [7:0] p);
        int         slot;
        int         idx;
        bit         drive;
        bit         bnd;
        logic [3:0] ec;
        logic [7:0] ed;
        logic       edp;
        logic       eft;
        logic       eup;

        bus.load     = ld;
        bus.codes    = c;
        bus.digit_en = e;
        bus.points   = p;

        slot  = m_t % P;
        idx   = (m_t / P) % 8;
        ec    = 4'(m_act_codes >> (4 * idx));
        drive = (slot >= B) && m_act_en[idx];
        ed    = drive ? ~(8'(1) << idx) : 8'hFF;
        edp   = !(drive && m_act_pts[idx]);
        eft   = ((m_t % FRAME) == 0);
        eup   = m_swapped;

        bnd       = ((m_t % FRAME) == FRAME - 1);
        m_swapped = 1'b0;
        if (bnd && m_pv) begin
            m_act_codes = m_pend_codes;
            m_act_en    = m_pend_en;
            m_act_pts   = m_pend_pts;
            m_pv        = 1'b0;
            m_swapped   = 1'b1;
        end
        if (ld) begin
            m_pend_codes = c;
            m_pend_en    = e;
            m_pend_pts   = p;
            m_pv         = 1'b1;
        end
        m_t++;

        @(posedge clk);
        @(negedge clk);
        bus.load = 1'b0;
        if (bus.updated === 1'b1) n_upd++;
        check("code_out", 32'(bus.code_out), 32'(ec));
        check("digit", 32'(bus.digit), 32'(ed));
        check("dp", 32'(bus.dp), 32'(edp));
        check("frame_tick", 32'(bus.frame_tick), 32'(eft));
        check("updated", 32'(bus.updated), 32'(eup));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom, 8'($urandom), 8'($urandom));
    endtask

    task automatic advance_to(input int phase);
        for (int i = 0; i < FRAME && (m_t % FRAME) != phase; i++) idle(1);
    endtask

    initial begin
        rst          = 1'b1;
        bus.load     = 1'b0;
        bus.codes    = '0;
        bus.digit_en = '0;
        bus.points   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset();

        // No load: blank display, frame ticks only.
        n_upd = 0;
        idle(40);
        check("no_load_updates", 32'(n_upd), 32'd0);

        // First frame with all digits enabled, point on digit 0.
        n_upd = 0;
        step(1'b1, 32'h9876_3435, 8'hFF, 8'h01);
        idle(2 * FRAME);
        check("first_load_updates", 32'(n_upd), 32'd1);

        // Upper four digits disabled.
        step(1'b1, 32'h1234_5678, 8'h0F, 8'hA5);
        idle(2 * FRAME);

        // Two loads in one frame: latest wins, single update.
        advance_to(2);
        n_upd = 0;
        step(1'b1, 32'h1111_1111, 8'hFF, 8'h00);
        idle(5);
        step(1'b1, 32'h2345_6789, 8'hF0, 8'h3C);
        idle(2 * FRAME);
        check("latest_wins_updates", 32'(n_upd), 32'd1);

        // Load on the boundary cycle with pending valid.
        advance_to(10);
        step(1'b1, 32'hAAAA_5555, 8'hFF, 8'hFF);
        advance_to(FRAME - 1);
        n_upd = 0;
        step(1'b1, 32'h0F0F_F0F0, 8'h5A, 8'h0F);
        idle(2 * FRAME);
        check("boundary_load_updates", 32'(n_upd), 32'd2);

        // Reset during digit 5 with pending valid: pending discarded.
        advance_to(3 * P + 1);
        step(1'b1, 32'h7654_3210, 8'hFF, 8'hFF);
        advance_to(5 * P + 2);
        do_reset();
        n_upd = 0;
        idle(2 * FRAME);
        check("post_reset_updates", 32'(n_upd), 32'd0);

        // Randomized loads and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r == 0) do_reset();
            else step(r < 10, $urandom, 8'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
